// File: rtl/sync_pkg.sv
// Shared definitions for the synchronize / filter / edge-detect block.
//   MODE_*      : edge-select encodings for the 2-bit mode input
//   edge_match  : decides whether a level update in a given direction pulses
package sync_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_RISE = 2'b00;
    localparam logic [MODE_W-1:0] MODE_FALL = 2'b01;
    localparam logic [MODE_W-1:0] MODE_BOTH = 2'b10;
    localparam logic [MODE_W-1:0] MODE_NONE = 2'b11;

    // new_level is the value the filtered level is about to take; the update
    // is a rise when it is 1 and a fall when it is 0.
    function automatic logic edge_match(input logic [MODE_W-1:0] mode,
                                        input logic              new_level);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_RISE: r = new_level;
            MODE_FALL: r = ~new_level;
            MODE_BOTH: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: STAGES-deep synchronizer, persistence filter and edge pulse.
//   clk, rst_n : clock, async active-low reset
//   en         : filter / edge-detect enable (synchronizer always shifts)
//   mode       : edge select (sync_pkg MODE_*)
//   d_async    : asynchronous input bit
//   sync_raw   : last synchronizer stage
//   level      : filtered, accepted level
//   pulse      : one-cycle pulse after a matching level update
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int unsigned STAGES   = 2,
    parameter int unsigned FILT_CYC = 4,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              d_async,
    output logic              sync_raw,
    output logic              level,
    output logic              pulse
);

    localparam int unsigned       CNT_W    = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [STAGES-1:0] r_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_level;
    logic              w_level_nxt;
    logic              r_pulse;
    logic              w_pulse_nxt;
    logic              w_raw;
    logic              w_diff;

    assign w_raw  = r_sync[STAGES-1];
    assign w_diff = (w_raw != r_level);

    // Synchronizer chain, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_async};
        end
    end

    // Persistence filter: a difference must survive FILT_CYC enabled edges.
    // Any agreement or en=0 restarts the count from zero.
    always_comb begin
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        if (en && w_diff) begin
            if (r_cnt == CNT_LAST) begin
                w_level_nxt = w_raw;
                w_pulse_nxt = edge_match(mode, w_raw);
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Filter and pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= RST_VAL;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign sync_raw = w_raw;
    assign level    = r_level;
    assign pulse    = r_pulse;

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel synchronizer + glitch filter + edge detector.
//   clk, rst_n : clock, async active-low reset
//   en         : filter / edge-detect enable
//   mode       : edge select 00 rise, 01 fall, 10 both, 11 none
//   d_async    : CH asynchronous inputs
//   sync_raw   : synchronized, unfiltered values
//   level      : filtered levels
//   pulse      : per-channel one-cycle edge pulses
//   pulse_any  : OR of pulse, no added latency
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int unsigned     CH       = 4,
    parameter int unsigned     STAGES   = 2,
    parameter int unsigned     FILT_CYC = 4,
    parameter logic [CH-1:0]   RST_VAL  = {CH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [CH-1:0]     d_async,
    output logic [CH-1:0]     sync_raw,
    output logic [CH-1:0]     level,
    output logic [CH-1:0]     pulse,
    output logic              pulse_any
);

    logic [CH-1:0] w_pulse;

    // One fully independent filter per channel.
    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        sync_filter_ch #(
            .STAGES   (STAGES),
            .FILT_CYC (FILT_CYC),
            .RST_VAL  (RST_VAL[g])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .mode     (mode),
            .d_async  (d_async[g]),
            .sync_raw (sync_raw[g]),
            .level    (level[g]),
            .pulse    (w_pulse[g])
        );
    end

    assign pulse     = w_pulse;
    assign pulse_any = |w_pulse;

endmodule

// File: tb/tb_sync_filter_edge.sv
module tb_sync_filter_edge;

    localparam int CH       = 4;
    localparam int STAGES   = 2;
    localparam int FILT_CYC = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [CH-1:0] d_async;
    logic [CH-1:0] sync_raw;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic          pulse_any;

    int n_cmp;
    int n_bad;

    sync_filter_edge #(
        .CH       (CH),
        .STAGES   (STAGES),
        .FILT_CYC (FILT_CYC),
        .RST_VAL  ({CH{1'b0}})
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .d_async   (d_async),
        .sync_raw  (sync_raw),
        .level     (level),
        .pulse     (pulse),
        .pulse_any (pulse_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: d_async delayed by STAGES edges gives sync_raw. A level
    // takes a new value once sync_raw disagreed with it on each of the last
    // FILT_CYC edges with en high (a window spanning an earlier update always
    // contains a sample equal to the current level, so it cannot re-trigger).
    logic [CH-1:0] m_pipe [STAGES];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_pulse;
    logic [CH-1:0] h_raw [$];
    bit            h_en  [$];

    function automatic bit mode_hit(input logic [1:0] md, input logic newv);
        if (md == 2'd0) return newv == 1'b1;
        if (md == 2'd1) return newv == 1'b0;
        if (md == 2'd2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < STAGES; s++) m_pipe[s] = '0;
        m_level = '0;
        m_pulse = '0;
        h_raw.delete();
        h_en.delete();
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [CH-1:0] raw;
        bit            all_diff;
        if (!rst_n) return;
        raw = m_pipe[STAGES-1];
        h_raw.push_back(raw);
        h_en.push_back(en);
        if (h_raw.size() > FILT_CYC) begin
            void'(h_raw.pop_front());
            void'(h_en.pop_front());
        end
        m_pulse = '0;
        for (int i = 0; i < CH; i++) begin
            all_diff = (h_raw.size() == FILT_CYC);
            for (int k = 0; k < h_raw.size(); k++)
                if (!h_en[k] || h_raw[k][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[i] = raw[i];
                m_pulse[i] = mode_hit(mode, raw[i]);
            end
        end
        for (int s = STAGES - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = d_async;
    endtask

    // One clock: model the coming edge, then return at the following negedge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle_zero();
        d_async = '0;
        en      = 1'b1;
        for (int c = 0; c < STAGES + FILT_CYC + 2; c++) tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        d_async = 4'hF;
        mode    = 2'b10;
        en      = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (sync_raw !== 4'h0 || level !== 4'h0 || pulse !== 4'h0 || pulse_any !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: sync_raw=%h level=%h pulse=%h any=%b, want 0/0/0/0",
                     sync_raw, level, pulse, pulse_any);
        end
        @(negedge clk);
        d_async = '0;
        @(negedge clk);
        rst_n = 1'b1;
        settle_zero();
    endtask

    task automatic test_rise();
        mode       = 2'b00;
        d_async[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_cmp++;
            if (sync_raw[0] !== (e >= 2) || level[0] !== (e >= 6) || pulse[0] !== (e == 6)
                || pulse_any !== (e == 6)) begin
                n_bad++;
                $display("FAIL rise_E%0d: sync_raw0=%b level0=%b pulse0=%b any=%b, want %b %b %b %b",
                         e, sync_raw[0], level[0], pulse[0], pulse_any,
                         e >= 2, e >= 6, e == 6, e == 6);
            end
        end
    endtask

    task automatic test_glitch();
        mode = 2'b10;
        d_async[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) d_async[1] = 1'b0;
            tick();
            n_cmp++;
            if (sync_raw[1] !== (e >= 2 && e <= 4) || level[1] !== 1'b0 || pulse[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_E%0d: sync_raw1=%b level1=%b pulse1=%b, want %b 0 0",
                         e, sync_raw[1], level[1], pulse[1], e >= 2 && e <= 4);
            end
        end
    endtask

    task automatic test_edge_modes();
        int p_at [$];
        // Channel 2 in both-edge mode: pulses exactly 10 cycles apart.
        mode = 2'b10;
        d_async[2] = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            if (e == 11) d_async[2] = 1'b0;
            tick();
            if (pulse[2] === 1'b1) p_at.push_back(e);
            n_cmp++;
            if (pulse !== m_pulse || level !== m_level) begin
                n_bad++;
                $display("FAIL both_E%0d: pulse=%h level=%h, want %h %h", e, pulse, level, m_pulse, m_level);
            end
        end
        n_cmp++;
        if (p_at.size() != 2 || p_at[0] != 6 || p_at[1] != 16) begin
            n_bad++;
            $display("FAIL both_pulses: got %0d pulses first=%0d, want 2 at 6 and 16",
                     p_at.size(), p_at.size() > 0 ? p_at[0] : -1);
        end
        // Channel 3 in fall mode: only the falling update pulses.
        p_at.delete();
        mode = 2'b01;
        d_async[3] = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            if (e == 11) d_async[3] = 1'b0;
            tick();
            if (pulse[3] === 1'b1) p_at.push_back(e);
        end
        n_cmp++;
        if (p_at.size() != 1 || p_at[0] != 16) begin
            n_bad++;
            $display("FAIL fall_pulses: got %0d pulses first=%0d, want 1 at 16",
                     p_at.size(), p_at.size() > 0 ? p_at[0] : -1);
        end
    endtask

    task automatic test_enable();
        // Level 0 rises: sync_raw after E2, counted at E3,E4, en low E5..E9.
        mode = 2'b00;
        d_async[0] = 1'b0;
        settle_zero();
        d_async[0] = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            en = !(e >= 5 && e <= 9);
            tick();
            n_cmp++;
            if (level[0] !== (e >= 13) || pulse[0] !== (e == 13) || level !== m_level) begin
                n_bad++;
                $display("FAIL enable_E%0d: level0=%b pulse0=%b, want %b %b",
                         e, level[0], pulse[0], e >= 13, e == 13);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        d_async = '0;
        settle_zero();
        mode = 2'b10;
        d_async[1] = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (level !== 4'h0 || pulse !== 4'h0 || sync_raw !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_mid: level=%h pulse=%h sync_raw=%h, want 0 0 0", level, pulse, sync_raw);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Input still high: needs full STAGES+FILT_CYC edges again.
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_cmp++;
            if (level[1] !== (e >= 6) || pulse[1] !== (e == 6)) begin
                n_bad++;
                $display("FAIL reset_release_E%0d: level1=%b pulse1=%b, want %b %b",
                         e, level[1], pulse[1], e >= 6, e == 6);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 5) == 0) d_async[i] = ~d_async[i];
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if (c % 700 == 350) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
            n_cmp++;
            if (sync_raw !== m_pipe[STAGES-1] || level !== m_level || pulse !== m_pulse
                || pulse_any !== (|m_pulse)) begin
                n_bad++;
                $display("FAIL random_c%0d: raw=%h level=%h pulse=%h any=%b, want %h %h %h %b",
                         c, sync_raw, level, pulse, pulse_any,
                         m_pipe[STAGES-1], m_level, m_pulse, |m_pulse);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rise();
        test_glitch();
        test_edge_modes();
        test_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
